// File: rtl/maze_pkg.sv
// maze_pkg: shared direction and player-state types for the maze path player.
package maze_pkg;

    typedef enum logic [1:0] {
        UP    = 2'd0,
        RIGHT = 2'd1,
        DOWN  = 2'd2,
        LEFT  = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        FETCH,
        WAIT,
        EMIT,
        PACE,
        FINISH
    } player_state_t;

endpackage

// File: rtl/pace_counter.sv
// pace_counter: loadable down-counter with a zero flag, used to space move pulses.
module pace_counter #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb cnt_d = clr_i ? '0 : load_i ? load_val_i : (dec_i && cnt_q != '0) ? cnt_q - W'(1) : cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign zero_o = cnt_q == '0;

endmodule

// File: rtl/maze_path_player.sv
// maze_path_player: replays a solved maze path from the path stack as paced move pulses.
// Define PLAYER_LOOP_EN to replay the path continuously while run stays high.
module maze_path_player
    import maze_pkg::*;
#(
    parameter int DEPTH_W     = 8,
    parameter int PACE_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               solved,
    input  logic               fail,
    input  logic               run,
    input  logic [DEPTH_W-1:0] stack_depth,
    output logic [DEPTH_W-1:0] rd_addr,
    input  logic [1:0]         rd_data,
    output logic               move,
    output logic [1:0]         dir,
    output logic               busy,
    output logic               finished
);

    localparam int PACE_W = (PACE_CYCLES > 1) ? $clog2(PACE_CYCLES) : 1;

    player_state_t      state_q, state_d;
    logic [DEPTH_W-1:0] index_q, index_d, depth_q, depth_d;
    dir_t               dir_q, dir_d;
    logic               pace_load, pace_dec, pace_zero;

    pace_counter #(.W(PACE_W)) u_pace (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start),
        .load_i     (pace_load),
        .load_val_i (PACE_W'(PACE_CYCLES - 1)),
        .dec_i      (pace_dec),
        .zero_o     (pace_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            index_q <= '0;
            depth_q <= '0;
            dir_q   <= UP;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            depth_q <= depth_d;
            dir_q   <= dir_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        depth_d   = depth_q;
        dir_d     = dir_q;
        pace_load = 1'b0;
        pace_dec  = 1'b0;
        if (start) begin
            state_d = IDLE;
            index_d = '0;
            dir_d   = UP;
        end else begin
            case (state_q)
                IDLE: if (solved && !fail) begin
                    depth_d = stack_depth;
                    state_d = ARMED;
                end
                ARMED: if (run) begin
                    index_d = '0;
                    state_d = (depth_q == '0) ? FINISH : FETCH;
                end
                FETCH: state_d = run ? WAIT : FETCH;
                WAIT: begin
                    dir_d   = dir_t'(rd_data);
                    state_d = EMIT;
                end
                // The index stops at depth-1 so rd_addr never points past the path.
                EMIT: if (index_q == depth_q - DEPTH_W'(1)) begin
                    state_d = FINISH;
                end else begin
                    index_d   = index_q + DEPTH_W'(1);
                    pace_load = 1'b1;
                    state_d   = PACE;
                end
                PACE: begin
                    pace_dec = !pace_zero;
                    state_d  = pace_zero ? FETCH : PACE;
                end
`ifdef PLAYER_LOOP_EN
                FINISH: if (run && depth_q != '0) begin
                    index_d = '0;
                    state_d = FETCH;
                end
`else
                FINISH: state_d = FINISH;
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    assign rd_addr  = index_q;
    assign dir      = dir_q;
    assign move     = state_q == EMIT;
    assign busy     = state_q inside {FETCH, WAIT, EMIT, PACE};
    assign finished = state_q == FINISH;

endmodule

// File: tb/tb_maze_path_player.sv
// tb_maze_path_player: table-driven cycle checks plus hand-written abort sequences.
module tb_maze_path_player;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0, solved = 1'b0, fail = 1'b0, run = 1'b0;
    logic [7:0] stack_depth = 8'd0;
    logic [7:0] rd_addr;
    logic [1:0] rd_data = 2'd0;
    logic [1:0] dir;
    logic       move, busy, finished;
    logic [1:0] mem [0:255];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= mem[rd_addr];

    maze_path_player dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .solved      (solved),
        .fail        (fail),
        .run         (run),
        .stack_depth (stack_depth),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .move        (move),
        .dir         (dir),
        .busy        (busy),
        .finished    (finished)
    );

    typedef struct {
        logic        st, so, fa, rn;
        logic [7:0]  dp;
        logic [12:0] exp;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic st, so, fa, rn, input logic [7:0] dp,
                       input logic mv, input logic [1:0] dr, input logic bs, fn, input logic [7:0] ad);
        vec_t v;
        v.st = st; v.so = so; v.fa = fa; v.rn = rn; v.dp = dp;
        v.exp = {mv, dr, bs, fn, ad};
        tbl.push_back(v);
    endtask

    function automatic logic [12:0] outs();
        return {move, dir, busy, finished, rd_addr};
    endfunction

    task automatic chk(input string nm, input logic [12:0] act, input logic [12:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got move=%b dir=%0d busy=%b fin=%b addr=%0d, expected move=%b dir=%0d busy=%b fin=%b addr=%0d",
                     nm, act[12], act[11:10], act[9], act[8], act[7:0], exp[12], exp[11:10], exp[9], exp[8], exp[7:0]);
        end
    endtask

    task automatic step(input logic st, so, fa, rn, input logic [7:0] dp);
        start = st; solved = so; fail = fa; run = rn; stack_depth = dp;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int pulses;
        int busy_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 2'd0;
        mem[0] = 2'd1; mem[1] = 2'd2; mem[2] = 2'd3;

        // solved with fail stays idle
        add(0,1,1,0,3, 0,0,0,0,0);
        add(0,1,1,1,3, 0,0,0,0,0);
        add(0,0,0,1,3, 0,0,0,0,0);
        // depth 3 replay R,D,L; stack_depth input changes after arming must not matter
        add(0,1,0,0,3, 0,0,0,0,0);
        add(0,0,0,1,0, 0,0,1,0,0);
        add(0,0,0,1,0, 0,0,1,0,0);
        add(0,0,0,1,0, 1,1,1,0,0);
        for (int k = 0; k < 4; k++) add(0,0,0,1,0, 0,1,1,0,1);
        add(0,0,0,1,0, 0,1,1,0,1);
        add(0,0,0,1,0, 0,1,1,0,1);
        add(0,0,0,1,0, 1,2,1,0,1);
        for (int k = 0; k < 4; k++) add(0,0,0,1,0, 0,2,1,0,2);
        add(0,0,0,1,0, 0,2,1,0,2);
        add(0,0,0,1,0, 0,2,1,0,2);
        add(0,0,0,1,0, 1,3,1,0,2);
        add(0,0,0,1,0, 0,3,0,1,2);
        add(0,0,0,1,0, 0,3,0,1,2);
        add(1,0,0,1,0, 0,0,0,0,0);
        // depth 0 finishes immediately; start beats solved
        add(0,1,0,0,0, 0,0,0,0,0);
        add(0,0,0,1,0, 0,0,0,1,0);
        add(0,0,0,1,0, 0,0,0,1,0);
        add(1,1,0,0,3, 0,0,0,0,0);
        add(0,0,0,0,3, 0,0,0,0,0);
        // run dropped after first pulse holds FETCH, resumes two cycles after run returns
        add(0,1,0,0,3, 0,0,0,0,0);
        add(0,0,0,1,3, 0,0,1,0,0);
        add(0,0,0,1,3, 0,0,1,0,0);
        add(0,0,0,0,3, 1,1,1,0,0);
        for (int k = 0; k < 7; k++) add(0,0,0,0,3, 0,1,1,0,1);
        add(0,0,0,1,3, 0,1,1,0,1);
        add(0,0,0,1,3, 1,2,1,0,1);
        add(1,0,0,0,3, 0,0,0,0,0);

        #2 rst = 1'b1;
        #1 chk("reset", outs(), 13'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        foreach (tbl[i]) begin
            step(tbl[i].st, tbl[i].so, tbl[i].fa, tbl[i].rn, tbl[i].dp);
            chk($sformatf("vec%0d", i), outs(), tbl[i].exp);
        end

        // start mid-PACE
        step(0,1,0,0,3);
        step(0,0,0,1,3);
        step(0,0,0,1,3);
        step(0,0,0,1,3);
        step(0,0,0,1,3);
        chk("pace_entry", outs(), {1'b0, 2'd1, 1'b1, 1'b0, 8'd1});
        step(1,0,0,1,3);
        chk("start_mid_pace", outs(), 13'd0);
        pulses = 0; busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0,0,0,1,3);
            pulses += int'(move);
            busy_cnt += int'(busy);
        end
        chk("after_start_quiet", {1'b0, 2'd0, 2'b0, 8'(pulses + busy_cnt)}, 13'd0);

        // async reset mid-WAIT
        step(0,1,0,0,3);
        step(0,0,0,1,3);
        step(0,0,0,1,3);
        chk("wait_entry", outs(), {1'b0, 2'd0, 1'b1, 1'b0, 8'd0});
        #2 rst = 1'b1;
        #1 chk("rst_mid_wait", outs(), 13'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        pulses = 0; busy_cnt = 0;
        for (int k = 0; k < 20; k++) begin
            step(0,0,0,1,3);
            pulses += int'(move);
            busy_cnt += int'(busy);
        end
        chk("after_rst_quiet", {1'b0, 2'd0, 2'b0, 8'(pulses + busy_cnt)}, 13'd0);
        chk("after_rst_idle", outs(), 13'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
